serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
//
// PURPOSE
//   Serial bit-pattern transmitter for the sequence detectors in this design.
//   On a start request it captures a PAT_W-bit pattern and shifts it out MSB-first, one bit per clk.
//   The pattern is sent REPEAT times, with GAP_CYC idle-zero cycles between frames.
//   It drives the serial `in` line of a downstream run/sequence detector and reports busy/done.
//
// PARAMETERS
//   PAT_W    8   pattern width in bits (>=2)
//   CNT_W    4   width of repeat-count input
//   GAP_CYC  2   idle cycles (out=0) between repeated frames; 0 = frames back-to-back
//
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; sampled only in IDLE or DONE
//   pattern    in   PAT_W  bits to send, captured when start is accepted
//   repeat     in   CNT_W  number of frames to send; 0 treated as 1
//   out        out  1      serial data bit (registered)
//   out_valid  out  1      1 while out carries a pattern/parity bit
//   busy       out  1      1 from first bit through last bit of the last frame
//   done       out  1      1-cycle pulse, cycle after the last bit
//
// BEHAVIOUR
//   - Reset (async, reset=1): state=IDLE; out, out_valid, busy, done = 0; shift reg, counters = 0.
//   - All outputs registered. One clk in IDLE/DONE with start=1 is "accept".
//   - Accept captures pattern/repeat. The next cycle is SHIFT with out=pattern[PAT_W-1]. Latency is 1 cycle.
//   - SHIFT: PAT_W cycles, MSB->LSB; out_valid=1, busy=1; bit counter counts 0..PAT_W-1.
//   - PARITY (macro only): 1 cycle; out = ^pattern (even parity), out_valid=1.
//   - End of frame, frames left > 0:
//     - GAP_CYC>0: enter GAP for GAP_CYC cycles; out=0, out_valid=0, busy=1. Then SHIFT, reloading the captured pattern.
//     - GAP_CYC=0: next cycle is SHIFT of the next frame, with no bubble.
//   - End of last frame: DONE for 1 cycle; done=1, busy=0, out=0, out_valid=0. Then IDLE.
//   - States: IDLE, SHIFT, PARITY, GAP, DONE. Unreachable encodings go to IDLE.
//   - start while busy: ignored; the pattern/repeat inputs are not re-sampled.
//   - start in DONE: accepted, so back-to-back transactions leave 1 dead cycle. The next SHIFT follows directly.
//   - repeat=0 behaves exactly as repeat=1.
//   - Frame counter decrements at each frame end and never wraps.
//   - Reset mid-frame: output drops to 0 asynchronously. No done pulse is generated.
//   - Idle line level is 0, so a downstream run-of-ones detector sees no spurious ones between frames.
//
// CONFIGURATION
//   `SERIAL_PATTERN_TX_PARITY_EN defined:
//     - Each frame is PAT_W+1 bits; an even-parity bit follows the LSB.
//     - The PARITY state exists.
//   Not defined:
//     - Frame is PAT_W bits; PARITY state and parity logic are absent.
//     - SHIFT LSB cycle goes directly to GAP, SHIFT or DONE.
//
// STRUCTURE
//   - Shared header serial_pattern_defs.vh holds the state encodings (IDLE..DONE, 3-bit) and default widths.
//     The serial_pattern_tx and detector benches both use it.
//   - Sub-module pattern_shreg: loadable PAT_W shift register with parallel load, shift-left, serial MSB out and XOR-reduce output.
//   - Top level holds the FSM, bit counter, gap counter and frame counter.
//
// TESTING
//   1 pattern=8'b1011_0010, repeat=1, start 1 cycle:
//     out = 1,0,1,1,0,0,1,0 on cycles 1..8 after accept; done=1 at cycle 9.
//   2 pattern=8'hF0, repeat=3, GAP_CYC=2:
//     3 frames of 11110000 separated by exactly 2 out_valid=0 zero cycles; busy high throughout; single done.
//   3 repeat=0, pattern=8'hFF: identical to repeat=1; out 8 ones; a downstream 4-ones detector asserts on the 4th one.
//   4 start held high during a frame with pattern changed to 8'h00: the transmitted frame is unchanged.
//     A new frame starts the cycle after done.
//   5 reset pulsed at bit 4 of a frame:
//     out, out_valid, busy drop immediately, done is never pulsed, and the next start transmits cleanly.
//   6 With `SERIAL_PATTERN_TX_PARITY_EN, pattern=8'b0000_0111: 9 bits, last=1. With pattern=8'h03: last bit=0.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encodings,
// default widths and a counter-width helper.
package serial_pattern_tx_pkg;

  localparam int PAT_W_DEF   = 8;
  localparam int CNT_W_DEF   = 4;
  localparam int GAP_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_shreg.sv
// Loadable PAT_W shift register: parallel load, shift-left with zero fill,
// serial MSB out. Holds the XOR-reduce of the last load when
// SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx_shreg #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_data,
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  output logic             o_parity,
`endif
  output logic             o_msb
);

  logic [PAT_W-1:0] r_sr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else begin
      r_sr <= {r_sr[PAT_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[PAT_W-1];

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic r_parity;

  // Loading {parity, zeros} re-captures the same parity, so it stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (i_load) begin
      r_parity <= ^i_data;
    end
  end

  assign o_parity = r_parity;
`endif

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first REPEAT
// times with idle-zero gaps. Optional even-parity bit: SERIAL_PATTERN_TX_PARITY_EN.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W    = cnt_width(PAT_W);
  localparam int GAP_W    = cnt_width(GAP_CYC);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  state_e           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [CNT_W-1:0] r_frames;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last_bit;
  logic             w_frame_end;
  logic             w_more;
  logic             w_gap_end;
  logic             w_reload;
  logic             w_load;
  logic [PAT_W-1:0] w_load_data;
  logic             w_msb;

  assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_W'(PAT_W - 1));
  assign w_more     = (r_frames > CNT_W'(1));
  assign w_gap_end  = (r_state == ST_GAP) && (r_gap_cnt == GAP_W'(GAP_LAST));
  assign w_reload   = (w_frame_end && w_more && (GAP_CYC == 0)) || w_gap_end;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic w_parity;
  assign w_frame_end = (r_state == ST_PARITY);
`else
  assign w_frame_end = w_last_bit;
`endif

  // The shift register itself is the `out` flop; it drains to zero whenever it
  // is not reloaded, which keeps the line low in GAP, DONE and IDLE.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_load      = 1'b0;
    w_load_data = r_pattern;
    if (w_accept) begin
      w_load      = 1'b1;
      w_load_data = pattern;
    end else if (w_reload) begin
      w_load      = 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    end else if (w_last_bit) begin
      w_load      = 1'b1;
      w_load_data = {w_parity, {(PAT_W-1){1'b0}}};
`endif
    end
  end

  serial_pattern_tx_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_data   (w_load_data),
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    .o_parity (w_parity),
`endif
    .o_msb    (w_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_frames  <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (start) begin
            r_pattern <= pattern;
            r_frames  <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_bit_cnt <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            r_state   <= ST_PARITY;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        ST_PARITY: begin
          r_state <= ST_PARITY;
        end
`endif
        ST_GAP: begin
          if (w_gap_end) begin
            r_gap_cnt <= '0;
            r_valid   <= 1'b1;
            r_state   <= ST_SHIFT;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // Frame-end routing overrides the per-state defaults above.
      if (w_frame_end) begin
        r_frames <= r_frames - CNT_W'(1);
        if (w_more) begin
          if (GAP_CYC > 0) begin
            r_valid <= 1'b0;
            r_state <= ST_GAP;
          end else begin
            r_state <= ST_SHIFT;
          end
        end else begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
      end
    end
  end

  assign out       = w_msb;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed cases plus random
// transactions compared against a per-cycle expected waveform built from the frame rules.
module tb_serial_pattern_tx;

  localparam int PAT_W   = 8;
  localparam int CNT_W   = 4;
  localparam int GAP_CYC = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic o;
    logic v;
    logic b;
    logic d;
  } step_t;

  step_t exp_q[$];

  serial_pattern_tx #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected per-cycle waveform, starting the cycle after accept.
  task automatic build_model(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
    int n_frames;
    exp_q.delete();
    n_frames = (rep == 0) ? 1 : int'(rep);
    for (int f = 0; f < n_frames; f++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back('{pat[i], 1'b1, 1'b1, 1'b0});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      exp_q.push_back('{^pat, 1'b1, 1'b1, 1'b0});
`endif
      if (f < n_frames - 1)
        for (int g = 0; g < GAP_CYC; g++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  // Check the first n_chk expected steps; after the first one, apply new inputs
  // (start level, pattern, repeat) that the running transaction must ignore.
  task automatic check_stream(input string tag, input int n_chk, input logic keep_start,
                              input logic [PAT_W-1:0] nxt_pat, input logic [CNT_W-1:0] nxt_rep);
    for (int k = 0; k < n_chk; k++) begin
      @(negedge clk);
      check($sformatf("%s[%0d].out", tag, k),       out,       exp_q[k].o);
      check($sformatf("%s[%0d].out_valid", tag, k), out_valid, exp_q[k].v);
      check($sformatf("%s[%0d].busy", tag, k),      busy,      exp_q[k].b);
      check($sformatf("%s[%0d].done", tag, k),      done,      exp_q[k].d);
      if (k == 0) begin
        start      = keep_start;
        pattern    = nxt_pat;
        repeat_cnt = nxt_rep;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, ".out"},       out,       1'b0);
    check({tag, ".out_valid"}, out_valid, 1'b0);
    check({tag, ".busy"},      busy,      1'b0);
    check({tag, ".done"},      done,      1'b0);
  endtask

  task automatic run_txn(input string tag, input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
    @(negedge clk);
    start      = 1'b1;
    pattern    = pat;
    repeat_cnt = rep;
    build_model(pat, rep);
    check_stream(tag, exp_q.size(), 1'b0, PAT_W'($urandom), CNT_W'($urandom));
    check_idle({tag, ".idle"});
  endtask

  initial begin
    logic [PAT_W-1:0] rp;
    logic [CNT_W-1:0] rr;

    reset      = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    repeat (3) @(negedge clk);
    check("reset.out",       out,       1'b0);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.busy",      busy,      1'b0);
    check("reset.done",      done,      1'b0);
    reset = 1'b0;
    check_idle("idle0");

    // Single frame, MSB first, done on the cycle after the LSB.
    run_txn("t1", 8'b1011_0010, 4'd1);

    // Three frames separated by gap cycles, one done pulse.
    run_txn("t2", 8'hF0, 4'd3);

    // repeat=0 behaves as repeat=1.
    run_txn("t3", 8'hFF, 4'd0);

    // start held through the frame with a changed pattern: frame unchanged,
    // then the held start is accepted in DONE and the next frame follows.
    @(negedge clk);
    start      = 1'b1;
    pattern    = 8'hA5;
    repeat_cnt = 4'd1;
    build_model(8'hA5, 4'd1);
    check_stream("t4a", exp_q.size(), 1'b1, 8'h00, 4'd2);
    build_model(8'h00, 4'd2);
    check_stream("t4b", exp_q.size(), 1'b0, 8'h3C, 4'd5);
    check_idle("t4.idle");

    // Reset pulsed at bit 4: outputs drop asynchronously, no done pulse.
    @(negedge clk);
    start      = 1'b1;
    pattern    = 8'hFF;
    repeat_cnt = 4'd2;
    build_model(8'hFF, 4'd2);
    check_stream("t5", 4, 1'b0, 8'h00, 4'd0);
    #1 reset = 1'b1;
    #1;
    check("t5.async.out",       out,       1'b0);
    check("t5.async.out_valid", out_valid, 1'b0);
    check("t5.async.busy",      busy,      1'b0);
    check("t5.async.done",      done,      1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) check_idle($sformatf("t5.post[%0d]", i));
    run_txn("t5.clean", 8'b1011_0010, 4'd2);

    // Parity-relevant patterns (odd and even number of ones).
    run_txn("t6a", 8'b0000_0111, 4'd1);
    run_txn("t6b", 8'h03, 4'd1);

    // Random transactions, some back-to-back through DONE.
    for (int t = 0; t < 20; t++) begin
      rp = PAT_W'($urandom);
      rr = CNT_W'($urandom_range(0, 4));
      if (t % 4 == 3) begin
        @(negedge clk);
        start      = 1'b1;
        pattern    = rp;
        repeat_cnt = rr;
        build_model(rp, rr);
        check_stream($sformatf("r%0d.a", t), exp_q.size(), 1'b1, ~rp, CNT_W'(1));
        build_model(~rp, CNT_W'(1));
        check_stream($sformatf("r%0d.b", t), exp_q.size(), 1'b0, rp, rr);
        check_idle($sformatf("r%0d.idle", t));
      end else begin
        run_txn($sformatf("r%0d", t), rp, rr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
